fb_port_arbiter: RTL and testbench

//  Shares the single-port 300x54x12b framebuffer SRAM between the display read path and the

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_clear_seq.sv | 56 +++++
 rtl/fb_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry, bus widths and arbiter FSM encoding.
package fb_pkg;
  localparam int FB_W      = 300;
  localparam int FB_H      = 54;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_clear_seq.sv
// Clear sweep: walks addresses 0..DEPTH-1 one per clk with a latched colour,
// then pulses done_o on the cycle the final write is presented to the SRAM.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_W,
  parameter int DATA_WIDTH = FB_DATA_W,
  parameter int DEPTH      = FB_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic                  active_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] color_o,
  output logic                  last_o,
  output logic                  done_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic                  run_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  done_q;

  assign last_o   = run_q && (cnt_q == LAST_ADDR);
  assign active_o = run_q;
  assign addr_o   = cnt_q;
  assign color_o  = color_q;
  assign done_o   = done_q;

  // Sweep counter; start is only presented by the parent when no sweep runs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_o;
      if (start_i) begin
        run_q   <= 1'b1;
        cnt_q   <= '0;
        color_q <= color_i;
      end else if (run_q) begin
        if (last_o) begin
          run_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer SRAM arbiter: display reads vs draw writes, with
// read-streak starvation guard. Optional clear sweep enabled by FB_CLEAR_EN.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH    = FB_ADDR_W,
  parameter int DATA_WIDTH    = FB_DATA_W,
  parameter int DEPTH         = FB_DEPTH,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ack_o,
  input  logic                  clr_start_i,
  input  logic [DATA_WIDTH-1:0] clr_color_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [SW-1:0]         STREAK_MAX = SW'(MAX_RD_STREAK);
  localparam logic [ADDR_WIDTH-1:0] LIMIT      = ADDR_WIDTH'(DEPTH);

  fb_state_e             state_q, state_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  wr_ack_q;
  // [0] read issued (= rd_ack), [1] SRAM captured, [2] rd_valid
  logic [2:0]            vld_pipe_q;
  logic [1:0]            oob_pipe_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  in_clear, clr_go, clr_act, clr_last, clr_done;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;
  logic                  force_wr, gnt_rd, gnt_wr;

`ifdef FB_CLEAR_EN
  assign in_clear = (state_q == ST_CLEAR);
  assign clr_go   = clr_start_i && !in_clear;

  fb_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (clr_go),
    .color_i  (clr_color_i),
    .active_o (clr_act),
    .addr_o   (clr_addr),
    .color_o  (clr_data),
    .last_o   (clr_last),
    .done_o   (clr_done)
  );
`else
  logic unused_clr;
  assign unused_clr = clr_start_i ^ (^clr_color_i);
  assign in_clear   = 1'b0;
  assign clr_go     = 1'b0;
  assign clr_act    = 1'b0;
  assign clr_last   = 1'b0;
  assign clr_done   = 1'b0;
  assign clr_addr   = '0;
  assign clr_data   = '0;
`endif

  // Grant selection: clear blocks everything, read beats write unless the streak is exhausted.
  always_comb begin
    force_wr = wr_req_i && (streak_q == STREAK_MAX);
    gnt_rd   = !in_clear && !clr_go && rd_req_i && !force_wr;
    gnt_wr   = !in_clear && !clr_go && wr_req_i && !gnt_rd;
  end

  // Next state, streak and SRAM command; mem_write defaults low every cycle.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;

    if (clr_go) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE:  if (rd_req_i || wr_req_i)    state_d = ST_RUN;
        ST_RUN:   if (!(rd_req_i || wr_req_i)) state_d = ST_IDLE;
        ST_CLEAR: if (clr_last)                state_d = ST_IDLE;
        default:                               state_d = ST_IDLE;
      endcase
    end

    if (gnt_wr)                 streak_d = '0;
    else if (gnt_rd && wr_req_i) streak_d = streak_q + SW'(1);

    if (clr_act) begin
      mem_addr_d  = clr_addr;
      mem_wdata_d = clr_data;
      mem_write_d = 1'b1;
    end else if (gnt_rd) begin
      mem_addr_d  = rd_addr_i;
    end else if (gnt_wr) begin
      mem_addr_d  = wr_addr_i;
      mem_wdata_d = wr_data_i;
      mem_write_d = (wr_addr_i < LIMIT);
    end
  end

  // State, command and read-return registers; out-of-range reads return zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      wr_ack_q    <= 1'b0;
      vld_pipe_q  <= '0;
      oob_pipe_q  <= '0;
      rd_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wr_ack_q    <= gnt_wr;
      vld_pipe_q  <= {vld_pipe_q[1:0], gnt_rd};
      oob_pipe_q  <= {oob_pipe_q[0], (rd_addr_i >= LIMIT)};
      if (vld_pipe_q[1]) rd_data_q <= oob_pipe_q[1] ? '0 : mem_rdata_i;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rd_ack_o    = vld_pipe_q[0];
  assign rd_valid_o  = vld_pipe_q[2];
  assign rd_data_o   = rd_data_q;
  assign wr_ack_o    = wr_ack_q;
  assign clr_busy_o  = in_clear;
  assign clr_done_o  = clr_done;
  assign mem_addr_o  = mem_addr_q;
  assign mem_write_o = mem_write_q;
  assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter with a behavioural SRAM; random traffic is checked
// against a transaction-level model of the arbitration and memory contents.
module tb_fb_port_arbiter;
  localparam int DEPTH = 16200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req, clr_start;
  logic [13:0] rd_addr, wr_addr, mem_addr;
  logic [11:0] wr_data, clr_color, rd_data, mem_wdata, mem_rdata;
  logic        rd_ack, rd_valid, wr_ack, clr_busy, clr_done, mem_write;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
    .clr_start_i(clr_start), .clr_color_i(clr_color),
    .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .mem_addr_o(mem_addr), .mem_write_o(mem_write), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port SRAM, read-before-write.
  logic [11:0] sram [0:16383];
  always @(posedge clk) begin
    if (mem_write) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [11:0] d,
                          output bit acked, output logic mw);
    acked = 0; mw = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_ack) begin acked = 1; mw = mem_write; break; end
    end
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [13:0] a, output bit acked,
                         output int lat, output logic [11:0] d);
    acked = 0; lat = -1; d = 'x;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_ack) begin acked = 1; break; end
    end
    rd_req = 1'b0;
    if (acked) begin
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (rd_valid) begin lat = j; d = rd_data; break; end
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int lat;
    logic [11:0] d;
    rst = 1'b1; rd_req = 0; wr_req = 0; clr_start = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; clr_color = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_ack, rd_valid, rd_data, wr_ack, clr_busy, clr_done, mem_addr, mem_write, mem_wdata} !== '0)
      begin failures++; $display("FAIL reset_idle: outputs=%h required 0",
        {rd_ack, rd_valid, rd_data, wr_ack, clr_busy, clr_done, mem_addr, mem_write, mem_wdata}); end
    rst = 1'b0;
    rd_req = 1; rd_addr = 14'h003; wr_req = 1; wr_addr = 14'h204; wr_data = 12'h777;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rd_ack, rd_valid, rd_data, wr_ack, clr_busy, clr_done, mem_addr, mem_write, mem_wdata} !== '0)
      begin failures++; $display("FAIL reset_async: outputs=%h required 0",
        {rd_ack, rd_valid, rd_data, wr_ack, clr_busy, clr_done, mem_addr, mem_write, mem_wdata}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rd_ack !== 1'b0 || wr_ack !== 1'b0 || mem_write !== 1'b0)
        begin failures++; $display("FAIL reset_hold: rd_ack=%b wr_ack=%b mem_write=%b required 0", rd_ack, wr_ack, mem_write); end
    end
    rd_req = 0; wr_req = 0; rst = 1'b0;
    do_read(14'h003, ok, lat, d);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL reset_resume: acked=%b required 1", ok); end
  endtask

  task automatic test_wr_rd();
    bit ok; logic mw; int lat; logic [11:0] d;
    apply_reset();
    do_write(14'h005, 12'hABC, ok, mw);
    checks++;
    if (ok !== 1'b1 || mw !== 1'b1)
      begin failures++; $display("FAIL wr_basic: acked=%b mem_write=%b required 1 1", ok, mw); end
    do_read(14'h005, ok, lat, d);
    checks++;
    if (ok !== 1'b1 || lat != 2 || d !== 12'hABC)
      begin failures++; $display("FAIL rd_basic: acked=%b lat=%0d data=%h required 1 2 abc", ok, lat, d); end
  endtask

  task automatic test_same_addr();
    bit ok; logic mw; int lat; logic [11:0] d, got;
    int rc, wc;
    apply_reset();
    do_write(14'h010, 12'h111, ok, mw);
    rc = -1; wc = -1; got = 'x;
    rd_req = 1; rd_addr = 14'h010; wr_req = 1; wr_addr = 14'h010; wr_data = 12'h222;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_ack) begin rc = i; rd_req = 0; end
      if (wr_ack) begin wc = i; wr_req = 0; end
      if (rd_valid) begin got = rd_data; break; end
    end
    rd_req = 0; wr_req = 0;
    checks++;
    if (rc != 0 || wc != 1)
      begin failures++; $display("FAIL same_addr_order: rd_ack@%0d wr_ack@%0d required 0 1", rc, wc); end
    checks++;
    if (got !== 12'h111) begin failures++; $display("FAIL same_addr_old: data=%h required 111", got); end
    do_read(14'h010, ok, lat, d);
    checks++;
    if (d !== 12'h222) begin failures++; $display("FAIL same_addr_new: data=%h required 222", d); end
  endtask

  task automatic test_oob();
    bit ok; logic mw; int lat; logic [11:0] d;
    apply_reset();
    do_write(14'd16200, 12'h5A5, ok, mw);
    checks++;
    if (ok !== 1'b1 || mw !== 1'b0)
      begin failures++; $display("FAIL oob_write: acked=%b mem_write=%b required 1 0", ok, mw); end
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0) begin failures++; $display("FAIL oob_write_late: mem_write=%b required 0", mem_write); end
    do_read(14'd16200, ok, lat, d);
    checks++;
    if (ok !== 1'b1 || lat != 2 || d !== 12'h000)
      begin failures++; $display("FAIL oob_read: acked=%b lat=%0d data=%h required 1 2 000", ok, lat, d); end
    do_write(14'd16199, 12'h3C3, ok, mw);
    checks++;
    if (mw !== 1'b1) begin failures++; $display("FAIL last_addr_write: mem_write=%b required 1", mw); end
    do_read(14'd16199, ok, lat, d);
    checks++;
    if (d !== 12'h3C3) begin failures++; $display("FAIL last_addr_read: data=%h required 3c3", d); end
  endtask

  task automatic test_streak();
    int rdcnt, wrdone;
    apply_reset();
    rdcnt = 0; wrdone = 0;
    rd_req = 1; rd_addr = 14'($urandom_range(0, 15));
    wr_req = 1; wr_addr = 14'h040; wr_data = 12'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_ack && wr_ack) begin checks++; failures++; $display("FAIL streak_dual_ack: cycle %0d both acks", i); end
      if (rd_ack) begin rdcnt++; rd_addr = 14'($urandom_range(0, 15)); end
      if (wr_ack) begin
        checks++;
        if (rdcnt != 4) begin failures++; $display("FAIL streak_count: reads before write=%0d required 4", rdcnt); end
        rdcnt = 0; wrdone++; wr_data = 12'($urandom);
        if (wrdone == 2) break;
      end
    end
    rd_req = 0; wr_req = 0;
    checks++;
    if (wrdone != 2) begin failures++; $display("FAIL streak_timeout: writes=%0d required 2", wrdone); end
  endtask

  typedef struct { int due; logic [11:0] d; bit kn; } exp_t;

  function automatic logic [13:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)      return 14'(14'h100 + $urandom_range(0, 7));
    else if (r < 9) return 14'(16196 + $urandom_range(0, 7));
    else            return 14'($urandom_range(0, 16383));
  endfunction

  task automatic test_random();
    logic [11:0] shadow [0:16383];
    bit known [0:16383];
    exp_t q[$];
    exp_t e;
    int streak_m;
    bit exp_rd, exp_wr, exp_mw, exp_vld;
    for (int i = 0; i < 16384; i++) known[i] = 0;
    apply_reset();
    streak_m = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      exp_rd = rd_req && !(wr_req && streak_m == 4);
      exp_wr = wr_req && !exp_rd;
      exp_mw = exp_wr && (wr_addr < DEPTH);
      checks++;
      if (rd_ack !== exp_rd || wr_ack !== exp_wr)
        begin failures++; $display("FAIL rand_grant c%0d: rd_ack=%b wr_ack=%b required %b %b", cyc, rd_ack, wr_ack, exp_rd, exp_wr); end
      checks++;
      if (mem_write !== exp_mw)
        begin failures++; $display("FAIL rand_mem_write c%0d: mem_write=%b required %b", cyc, mem_write, exp_mw); end
      exp_vld = (q.size() > 0) && (q[0].due == cyc);
      checks++;
      if (rd_valid !== exp_vld)
        begin failures++; $display("FAIL rand_rd_valid c%0d: rd_valid=%b required %b", cyc, rd_valid, exp_vld); end
      if (exp_vld) begin
        e = q.pop_front();
        if (e.kn) begin
          checks++;
          if (rd_data !== e.d) begin failures++; $display("FAIL rand_rd_data c%0d: data=%h required %h", cyc, rd_data, e.d); end
        end
      end
      if (exp_rd) begin
        e.due = cyc + 2;
        if (rd_addr >= DEPTH) begin e.d = 12'h000; e.kn = 1; end
        else begin e.d = shadow[rd_addr]; e.kn = known[rd_addr]; end
        q.push_back(e);
        if (wr_req) streak_m++;
      end
      if (exp_wr) begin
        if (wr_addr < DEPTH) begin shadow[wr_addr] = wr_data; known[wr_addr] = 1; end
        streak_m = 0;
      end
      if (rd_ack) rd_req = 0;
      if (wr_ack) wr_req = 0;
      if (!rd_req && $urandom_range(0, 2) != 0) begin rd_req = 1; rd_addr = rand_addr(); end
      if (!wr_req && $urandom_range(0, 2) != 0) begin wr_req = 1; wr_addr = rand_addr(); wr_data = 12'($urandom); end
    end
    rd_req = 0; wr_req = 0;
    repeat (3) @(negedge clk);
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    bit ok; logic mw; int lat; logic [11:0] d, got;
    int busy_cnt, done_cnt, mw_cnt;
    bit rd_seen, wr_seen, rd_early, wr_early, got_ok;
    apply_reset();
    busy_cnt = 0; done_cnt = 0; mw_cnt = 0;
    rd_seen = 0; wr_seen = 0; rd_early = 0; wr_early = 0; got_ok = 0; got = 'x;
    clr_color = 12'hF00; clr_start = 1;
    for (int i = 0; i < 17000; i++) begin
      @(negedge clk);
      if (rd_ack) begin if (done_cnt == 0) rd_early = 1; rd_seen = 1; rd_req = 0; end
      if (wr_ack) begin if (done_cnt == 0) wr_early = 1; wr_seen = 1; wr_req = 0; end
      if (rd_valid) begin got = rd_data; got_ok = 1; end
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      if (mem_write && (clr_busy || clr_done)) mw_cnt++;
      clr_start = (i == 100);
      if (i == 100) clr_color = 12'h00F;
      if (i == 5) begin
        rd_req = 1; rd_addr = 14'h000;
        wr_req = 1; wr_addr = 14'h030; wr_data = 12'h0AB;
      end
      if (wr_seen && got_ok) break;
    end
    rd_req = 0; wr_req = 0; clr_start = 0;
    checks++;
    if (busy_cnt != DEPTH) begin failures++; $display("FAIL clr_busy_len: cycles=%0d required %0d", busy_cnt, DEPTH); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL clr_done_count: pulses=%0d required 1", done_cnt); end
    checks++;
    if (mw_cnt != DEPTH) begin failures++; $display("FAIL clr_writes: writes=%0d required %0d", mw_cnt, DEPTH); end
    checks++;
    if (!rd_seen || !wr_seen || rd_early || wr_early)
      begin failures++; $display("FAIL clr_pending: rd=%b wr=%b early_rd=%b early_wr=%b required 1 1 0 0", rd_seen, wr_seen, rd_early, wr_early); end
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL clr_rd0: data=%h required f00", got); end
    do_read(14'd16199, ok, lat, d);
    checks++;
    if (d !== 12'hF00) begin failures++; $display("FAIL clr_rd_last: data=%h required f00", d); end
    do_read(14'h030, ok, lat, d);
    checks++;
    if (d !== 12'h0AB) begin failures++; $display("FAIL clr_wr_after: data=%h required 0ab", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_wr_rd();
    test_same_addr();
    test_oob();
    test_streak();
    test_random();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
